// File: rtl/bdd_node_walker.sv
// ---------------------------------------------------------------------------
// bdd_node_walker
//
// Walks a binary decision diagram held in a synchronous-read node SRAM.
// One 32-bit node word is fetched per step. A decision node selects its low
// or high child from the latched variable assignment. The walk repeats until
// a terminal node is reached or an error ends it.
//
// Node word: [7] terminal flag, [0] terminal value, [31:24] variable index,
//            [23:16] low child (variable = 0), [15:8] high child (variable = 1).
//
// Ports:
//   i_clk, i_rst      clock and synchronous active-high reset
//   i_start           start request, honoured only when idle
//   i_root, i_vars    root address and variable assignment, latched on start
//   o_busy            high from the accepted start until o_done
//   o_done            one-cycle pulse at the end of a traversal
//   o_result          terminal value (0 on error)
//   o_error           0 ok, 1 bad variable, 2 bad child pointer, 3 step limit
//   o_steps           nodes decoded in the last traversal
//   o_mem_addr        registered SRAM read address
//   o_mem_req         high while o_mem_addr is a valid read request
//   i_mem_data        SRAM read data
// ---------------------------------------------------------------------------
module bdd_node_walker #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_VARS   = 8,
    parameter int MAX_STEPS  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_root,
    input  logic [NUM_VARS-1:0]   i_vars,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_result,
    output logic [1:0]            o_error,
    output logic [7:0]            o_steps,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_req,
    input  logic [DATA_WIDTH-1:0] i_mem_data
);

    localparam int VIDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam int VPAD   = 1 << VIDX_W;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EVAL
    } state_t;

    state_t              state_reg;
    logic [NUM_VARS-1:0] vars_reg;

    // Pad the assignment to a power of two so the variable lookup never
    // indexes past the vector; padded slots are only reachable for indices
    // already rejected as out of range.
    logic [VPAD-1:0] vars_pad;

    generate
        for (genvar gi = 0; gi < VPAD; gi++) begin : g_pad
            if (gi < NUM_VARS) begin : g_real
                assign vars_pad[gi] = vars_reg[gi];
            end else begin : g_zero
                assign vars_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // Node decode, valid while in EVAL.
    logic       node_term;
    logic       node_val;
    logic [7:0] var_idx;
    logic       var_bad;
    logic       var_val;
    logic [7:0] child;
    logic       child_bad;
    logic [7:0] steps_next;
    logic       step_limit;

    assign node_term  = i_mem_data[7];
    assign node_val   = i_mem_data[0];
    assign var_idx    = i_mem_data[31:24];
    assign var_bad    = 32'(var_idx) >= 32'(NUM_VARS);
    assign var_val    = vars_pad[var_idx[VIDX_W-1:0]];
    assign child      = var_val ? i_mem_data[15:8] : i_mem_data[23:16];
    // Any child bit above the address width points outside the SRAM.
    assign child_bad  = (child >> ADDR_WIDTH) != 8'd0;
    assign steps_next = o_steps + 8'd1;
    assign step_limit = steps_next == 8'(MAX_STEPS);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            vars_reg   <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_result   <= 1'b0;
            o_error    <= 2'd0;
            o_steps    <= 8'd0;
            o_mem_addr <= '0;
            o_mem_req  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped so
                    // the controller sees a full idle cycle between runs.
                    if (i_start && !o_done) begin
                        o_mem_addr <= i_root;
                        vars_reg   <= i_vars;
                        o_steps    <= 8'd0;
                        o_error    <= 2'd0;
                        o_result   <= 1'b0;
                        o_busy     <= 1'b1;
                        o_mem_req  <= 1'b1;
                        state_reg  <= READ;
                    end
                end
                READ: begin
                    // SRAM samples o_mem_addr on this edge.
                    state_reg <= EVAL;
                end
                EVAL: begin
                    o_steps <= steps_next;
                    if (node_term || var_bad || child_bad || step_limit) begin
                        o_done    <= 1'b1;
                        o_busy    <= 1'b0;
                        o_mem_req <= 1'b0;
                        state_reg <= IDLE;
                        if (node_term) begin
                            o_result <= node_val;
                            o_error  <= 2'd0;
                        end else if (var_bad) begin
                            o_result <= 1'b0;
                            o_error  <= 2'd1;
                        end else if (child_bad) begin
                            o_result <= 1'b0;
                            o_error  <= 2'd2;
                        end else begin
                            o_result <= 1'b0;
                            o_error  <= 2'd3;
                        end
                    end else begin
                        o_mem_addr <= child[ADDR_WIDTH-1:0];
                        state_reg  <= READ;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bdd_node_walker.sv
module tb_bdd_node_walker;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  root;
    logic [7:0]  vars;
    logic        busy;
    logic        done;
    logic        result;
    logic [1:0]  error;
    logic [7:0]  steps;
    logic [3:0]  mem_addr;
    logic        mem_req;
    logic [31:0] mem_data;

    logic [31:0] mem [16];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        string       name;
        logic        result;
        logic [1:0]  err;
        int          steps;
        int          lat;
        int          naddr;
        logic [31:0] asig;
        int          start_cyc;
    } exp_t;

    exp_t exp_q[$];

    bdd_node_walker #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(32),
        .NUM_VARS(8),
        .MAX_STEPS(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_root(root),
        .i_vars(vars),
        .o_busy(busy),
        .o_done(done),
        .o_result(result),
        .o_error(error),
        .o_steps(steps),
        .o_mem_addr(mem_addr),
        .o_mem_req(mem_req),
        .i_mem_data(mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read SRAM model.
    always @(posedge clk) begin
        mem_data <= mem[mem_addr];
        cyc      <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: records the distinct read addresses of each traversal and
    // compares every done pulse against the head of the scoreboard.
    int          mon_naddr = 0;
    logic [31:0] mon_asig  = 0;
    logic [3:0]  mon_last  = 0;
    logic        busy_prev = 0;

    always @(negedge clk) begin
        if (busy && !busy_prev) begin
            mon_naddr = 0;
            mon_asig  = 0;
        end
        if (mem_req && (mon_naddr == 0 || mon_last != mem_addr)) begin
            mon_asig  = (mon_asig << 4) | 32'(mem_addr);
            mon_last  = mem_addr;
            mon_naddr++;
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("TXN %s: result=%0d error=%0d steps=%0d latency=%0d addrs=%0d sig=%h",
                         e.name, result, error, steps, cyc - e.start_cyc, mon_naddr, mon_asig);
                check({e.name, "_result"}, int'(result), int'(e.result));
                check({e.name, "_error"},  int'(error),  int'(e.err));
                check({e.name, "_steps"},  int'(steps),  e.steps);
                check({e.name, "_latency"}, cyc - e.start_cyc, e.lat);
                check({e.name, "_naddr"},  mon_naddr, e.naddr);
                check({e.name, "_addrs"},  int'(mon_asig), int'(e.asig));
            end
        end
        busy_prev = busy;
    end

    task automatic push_exp(input string name, input logic res, input logic [1:0] err,
                            input int st, input int lat, input int naddr, input logic [31:0] asig);
        exp_t e;
        e.name = name; e.result = res; e.err = err; e.steps = st; e.lat = lat;
        e.naddr = naddr; e.asig = asig; e.start_cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Issue a one-cycle start, then scramble root/vars to show they were latched.
    task automatic issue(input logic [3:0] r, input logic [7:0] v);
        root  = r;
        vars  = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        root  = ~r;
        vars  = ~v;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int done_seen;
        rst   = 1'b1;
        start = 1'b0;
        root  = 4'd0;
        vars  = 8'd0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0080;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_req",  int'(mem_req), 0);
        rst = 1'b0;
        @(negedge clk);

        // Terminal root
        mem[0] = 32'h0000_0081;
        push_exp("terminal_root", 1'b1, 2'd0, 1, 2, 1, 32'h0);
        issue(4'd0, 8'h00);
        wait_done("terminal_root", 50);
        @(negedge clk);

        // Single-variable node, both directions
        mem[0] = 32'h0001_0200;
        mem[1] = 32'h0000_0080;
        mem[2] = 32'h0000_0081;
        push_exp("var_high", 1'b1, 2'd0, 2, 4, 2, 32'h02);
        issue(4'd0, 8'h01);
        wait_done("var_high", 50);
        @(negedge clk);
        push_exp("var_low", 1'b0, 2'd0, 2, 4, 2, 32'h01);
        issue(4'd0, 8'h00);
        wait_done("var_low", 50);
        @(negedge clk);

        // Variable index out of range
        mem[3] = 32'h0901_0200;
        push_exp("var_range", 1'b0, 2'd1, 1, 2, 1, 32'h3);
        issue(4'd3, 8'hFF);
        wait_done("var_range", 50);
        @(negedge clk);

        // Child pointer out of range: only address 0 is ever requested
        mem[0] = 32'h0010_0200;
        push_exp("ptr_range", 1'b0, 2'd2, 1, 2, 1, 32'h0);
        issue(4'd0, 8'h00);
        wait_done("ptr_range", 50);
        @(negedge clk);

        // Self-loop hits the step limit
        mem[5] = 32'h0005_0500;
        push_exp("self_loop", 1'b0, 2'd3, 16, 32, 1, 32'h5);
        issue(4'd5, 8'h00);
        wait_done("self_loop", 100);

        // Start during the done cycle is ignored
        start = 1'b1;
        root  = 4'd5;
        @(negedge clk);
        start = 1'b0;
        check("start_on_done_busy", int'(busy), 0);
        check("hold_steps", int'(steps), 16);
        @(negedge clk);

        // Second start while busy is ignored
        mem[0] = 32'h0001_0200;
        push_exp("double_start", 1'b1, 2'd0, 2, 4, 2, 32'h02);
        issue(4'd0, 8'h01);
        root  = 4'd5;
        vars  = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("double_start", 50);
        @(negedge clk);

        // Reset at cycle 3 of a traversal aborts without done
        issue(4'd5, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",   int'(busy), 0);
        check("abort_req",    int'(mem_req), 0);
        check("abort_addr",   int'(mem_addr), 0);
        check("abort_steps",  int'(steps), 0);
        check("abort_error",  int'(error), 0);
        check("abort_result", int'(result), 0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);

        // Fresh start after the abort
        mem[0] = 32'h0000_0081;
        push_exp("after_reset", 1'b1, 2'd0, 1, 2, 1, 32'h0);
        issue(4'd0, 8'h00);
        wait_done("after_reset", 50);
        repeat (3) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
